// File: rtl/fetch_unit.sv
// Instruction fetch unit: three-phase fetch from synchronous memory with
// valid/ready hand-off and a return-address stack for call/return redirects.
module fetch_unit #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 32,
    parameter int RAS_DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_q,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [ADDR_WIDTH-1:0] pc_out,
    input  logic [1:0]            redirect_sel,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    input  logic                  call,
    output logic                  ras_empty,
    output logic                  ras_full,
    output logic                  fault
);

    localparam int CW = $clog2(RAS_DEPTH + 1);

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [ADDR_WIDTH-1:0] ras_d [RAS_DEPTH];
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  fault_q, fault_d;

    logic                  accept;
    logic [ADDR_WIDTH-1:0] seq_pc;
    logic [ADDR_WIDTH-1:0] top;

    assign accept = valid_q & instr_ready;
    assign seq_pc = pc_q + ADDR_WIDTH'(1);

    always_comb begin
        top = '0;
        for (int i = 0; i < RAS_DEPTH; i++) begin
            if (CW'(i + 1) == cnt_q) top = ras_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        ras_d   = ras_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        unique case (state_q)
            FETCH: state_d = WAIT;
            WAIT: begin
                state_d = HOLD;
                instr_d = imem_q;
                valid_d = 1'b1;
            end
            HOLD: begin
                if (accept) begin
                    state_d = FETCH;
                    valid_d = 1'b0;
                    pc_d    = seq_pc;
                    case (redirect_sel)
                        2'b01: begin
                            pc_d = redirect_target;
                            if (call) begin
                                if (full_q) begin
                                    fault_d = 1'b1;
                                end else begin
                                    for (int i = 0; i < RAS_DEPTH; i++) begin
                                        if (CW'(i) == cnt_q) ras_d[i] = seq_pc;
                                    end
                                    cnt_d = cnt_q + CW'(1);
                                end
                            end
                        end
                        2'b10: begin
                            // Underflow falls through to the sequential pc.
                            if (empty_q) begin
                                fault_d = 1'b1;
                            end else begin
                                pc_d  = top;
                                cnt_d = cnt_q - CW'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = FETCH;
        endcase
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == CW'(RAS_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            ras_q   <= ras_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            fault_q <= fault_d;
        end
    end

    assign imem_addr   = pc_q;
    assign pc_out      = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign ras_empty   = empty_q;
    assign ras_full    = full_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table of redirects plus hand
// sequences for hold, nested calls and reset during HOLD.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [17:0] imem_addr;
    logic [31:0] imem_q;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [17:0] pc_out;
    logic [1:0]  redirect_sel = 2'b00;
    logic [17:0] redirect_target = '0;
    logic        call = 1'b0;
    logic        ras_empty, ras_full, fault;

    int total = 0;
    int bad = 0;

    fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_addr       (imem_addr),
        .imem_q          (imem_q),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .pc_out          (pc_out),
        .redirect_sel    (redirect_sel),
        .redirect_target (redirect_target),
        .call            (call),
        .ras_empty       (ras_empty),
        .ras_full        (ras_full),
        .fault           (fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memval(input logic [17:0] a);
        return (a == 18'h0) ? 32'h1111_0000 : {14'h2AAA, a};
    endfunction

    always_ff @(posedge clk) imem_q <= memval(imem_addr);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && n < 20);
        if (!instr_valid) chk("valid_timeout", 32'(instr_valid), 32'd1);
    endtask

    task automatic accept(input logic [1:0] sel, input logic [17:0] tgt,
                          input logic c);
        redirect_sel    = sel;
        redirect_target = tgt;
        call            = c;
        instr_ready     = 1'b1;
        @(posedge clk);
        #1;
        instr_ready     = 1'b0;
        redirect_sel    = 2'b01;
        redirect_target = 18'h2BEEF;
        call            = 1'b1;
        chk("valid_drop", 32'(instr_valid), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [17:0] tgt;
        logic        call;
        logic [17:0] pc;
        logic        emp;
        logic        full;
        logic        flt;
    } vec_t;

    vec_t        tbl[10];
    logic [17:0] ret[9];
    logic [17:0] prev;
    logic [17:0] tgt;
    int          n;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2'b00, 18'h00000, 1'b0, 18'h00001, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{2'b01, 18'h00010, 1'b0, 18'h00010, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{2'b01, 18'h00100, 1'b1, 18'h00100, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{2'b11, 18'h00555, 1'b1, 18'h00101, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{2'b10, 18'h00777, 1'b0, 18'h00011, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{2'b01, 18'h3FFFF, 1'b0, 18'h3FFFF, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{2'b00, 18'h01234, 1'b0, 18'h00000, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{2'b01, 18'h00020, 1'b0, 18'h00020, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{2'b10, 18'h00000, 1'b0, 18'h00021, 1'b1, 1'b0, 1'b1};
        tbl[9] = '{2'b00, 18'h00000, 1'b0, 18'h00022, 1'b1, 1'b0, 1'b1};

        // Reset values while rst_n is low.
        #12;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_empty", 32'(ras_empty), 32'd1);
        chk("rst_full", 32'(ras_full), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        wait_valid(n);
        chk("first_lat", 32'(n), 32'd2);
        chk("first_instr", instr, 32'h1111_0000);
        chk("first_pc", 32'(pc_out), 32'd0);

        // Hold with noisy redirect inputs that must be ignored.
        redirect_sel    = 2'b01;
        redirect_target = 18'h2BEEF;
        call            = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_instr", instr, 32'h1111_0000);
            chk("hold_pc", 32'(pc_out), 32'd0);
            chk("hold_addr", 32'(imem_addr), 32'd0);
        end
        chk("hold_empty", 32'(ras_empty), 32'd1);

        for (int i = 0; i < 10; i++) begin
            accept(tbl[i].sel, tbl[i].tgt, tbl[i].call);
            wait_valid(n);
            chk("vec_lat", 32'(n), 32'd3);
            chk("vec_pc", 32'(pc_out), 32'(tbl[i].pc));
            chk("vec_instr", instr, memval(tbl[i].pc));
            chk("vec_empty", 32'(ras_empty), 32'(tbl[i].emp));
            chk("vec_full", 32'(ras_full), 32'(tbl[i].full));
            chk("vec_fault", 32'(fault), 32'(tbl[i].flt));
        end

        // Nine nested calls from a clean reset, then eight returns.
        do_reset();
        wait_valid(n);
        chk("rst2_fault", 32'(fault), 32'd0);
        prev = 18'h0;
        for (int k = 0; k < 9; k++) begin
            tgt = 18'(32'h1000 + k * 16);
            if (k < 8) ret[k] = prev + 18'd1;
            accept(2'b01, tgt, 1'b1);
            wait_valid(n);
            chk("call_pc", 32'(pc_out), 32'(tgt));
            chk("call_empty", 32'(ras_empty), 32'd0);
            chk("call_full", 32'(ras_full), (k >= 7) ? 32'd1 : 32'd0);
            chk("call_fault", 32'(fault), (k == 8) ? 32'd1 : 32'd0);
            prev = tgt;
        end
        for (int j = 7; j >= 0; j--) begin
            accept(2'b10, 18'h0, 1'b0);
            wait_valid(n);
            chk("ret_pc", 32'(pc_out), 32'(ret[j]));
            chk("ret_empty", 32'(ras_empty), (j == 0) ? 32'd1 : 32'd0);
            chk("ret_full", 32'(ras_full), 32'd0);
        end

        // Asynchronous reset in the middle of HOLD.
        @(negedge clk);
        chk("pre_rst_valid", 32'(instr_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(instr_valid), 32'd0);
        chk("async_instr", instr, 32'd0);
        chk("async_pc", 32'(pc_out), 32'd0);
        chk("async_fault", 32'(fault), 32'd0);
        chk("async_empty", 32'(ras_empty), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid(n);
        chk("refetch_lat", 32'(n), 32'd2);
        chk("refetch_pc", 32'(pc_out), 32'd0);
        chk("refetch_instr", instr, 32'h1111_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 18, instruction address width.
REQ-002 SHALL provide parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 SHALL provide parameter RAS_DEPTH, default 8, return-address stack entries.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port imem_addr  output  ADDR_WIDTH  address to synchronous instruction memory.
REQ-007 SHALL have port imem_q  input  DATA_WIDTH  memory data, valid one cycle after address sampled.
REQ-008 SHALL have port instr  output  DATA_WIDTH  registered instruction to control unit.
REQ-009 SHALL have port instr_valid  output  1  instr and pc_out are valid.
REQ-010 SHALL have port instr_ready  input  1  control unit accepts instr this cycle.
REQ-011 SHALL have port pc_out  output  ADDR_WIDTH  address of the held instr.
REQ-012 SHALL have port redirect_sel  input  2  next-PC select: 00 sequential, 01 target, 10 return, 11 sequential.
REQ-013 SHALL have port redirect_target  input  ADDR_WIDTH  absolute jump/branch target.
REQ-014 SHALL have port call  input  1  with sel=01, push return address.
REQ-015 SHALL have ports ras_empty, ras_full  output  1 each  stack occupancy flags.
REQ-016 SHALL have port fault  output  1  sticky stack overflow/underflow flag.

Function
REQ-017 SHALL implement states FETCH, WAIT, HOLD; FETCH->WAIT->HOLD unconditionally, HOLD->FETCH only on accept (instr_valid & instr_ready).
REQ-018 SHALL drive imem_addr = pc register in all states; pc changes only on accept.
REQ-019 SHALL capture imem_q into instr on the edge leaving WAIT; instr_valid=1 only in HOLD.
REQ-020 SHALL hold instr, pc_out, imem_addr stable while HOLD and instr_ready=0.
REQ-021 SHALL sample redirect_sel, redirect_target, call only on accept; ignored otherwise.
REQ-022 SHALL on accept with sel 00/11 load pc <= pc+1 modulo 2^ADDR_WIDTH (0x3FFFF -> 0x00000).
REQ-023 SHALL on accept with sel 01 load pc <= redirect_target; if call=1 also push (pc+1, wrapped).
REQ-024 SHALL on accept with sel 10 and stack non-empty load pc <= top entry and pop.
REQ-025 SHALL on push when full: leave stack unchanged, set fault, still take redirect_target.
REQ-026 SHALL on sel 10 when empty: leave stack unchanged, set fault, load pc <= pc+1.
REQ-027 SHALL ignore call when sel != 01.
REQ-028 SHALL assert ras_empty at count 0, ras_full at count RAS_DEPTH; count 0..RAS_DEPTH, registered.
REQ-029 SHALL keep fault set until reset.
REQ-030 SHALL sustain one instruction per 3 cycles with instr_ready held high.

Reset
REQ-031 SHALL on rst_n=0 immediately force state FETCH, pc=0, instr=0, instr_valid=0, stack count 0, ras_empty=1, ras_full=0, fault=0, regardless of current state.
REQ-032 SHALL begin fetch at address 0 on first clk edge after rst_n rises; reset during HOLD discards held instr.

Verification
REQ-033 Reset release, mem[0]=0x11110000 -> imem_addr=0, instr_valid=1 in third cycle after release with instr=0x11110000, pc_out=0.
REQ-034 instr_ready=0 for 5 cycles in HOLD -> instr, pc_out, imem_addr unchanged; then accept sel=00 -> next valid instr at pc_out=1 three cycles later.
REQ-035 At pc 0x00010 accept sel=01, call=1, target 0x00100 -> pc_out=0x00100, ras_empty=0; later accept sel=10 -> pc_out=0x00011, ras_empty=1, fault=0.
REQ-036 Nine nested calls -> ras_full=1 after eighth, ninth sets fault=1 yet pc_out=its target; eight returns unwind in LIFO order.
REQ-037 Return with empty stack at pc 0x00020 -> fault=1, next pc_out=0x00021.
REQ-038 Sequential accept at pc 0x3FFFF -> next pc_out=0x00000; rst_n pulsed low mid-HOLD -> instr_valid=0 asynchronously, refetch from 0.
